// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device command transmitter.
// Frame on the wire: start(0), eight data bits LSB first, odd parity, stop(1), device ack.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StInhibit  = 3'd1,
      StRts      = 3'd2,
      StData     = 3'd3,
      StAck      = 3'd4,
      StWaitIdle = 3'd5
   } ps2_state_e;

   localparam int unsigned DefInhibitCycles = 5000;
   localparam int unsigned DefTimeoutCycles = 750000;
   // Device clock falls in one host-to-device frame, including the ack.
   localparam int unsigned FrameFalls       = 11;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_cmd_tx_if.sv
// Command handshake and completion status between a host controller and ps2_cmd_tx.
interface ps2_cmd_tx_if;

   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       tx_done;
   logic       tx_error;
   logic       busy;

   modport master (
      output cmd_valid,
      output cmd_data,
      input  cmd_ready,
      input  tx_done,
      input  tx_error,
      input  busy
   );

   modport slave (
      input  cmd_valid,
      input  cmd_data,
      output cmd_ready,
      output tx_done,
      output tx_error,
      output busy
   );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 line plus falling-edge detect.
// Flops reset to 1 so an idle (released) line never produces a spurious fall.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic sync,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= line_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync = sync_q;
   assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_cmd_tx.sv
// PS/2 host command sender: inhibit the clock, request-to-send, shift out one byte
// with odd parity on device clock falls, then check the device acknowledge.
module ps2_cmd_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned INHIBIT_CYCLES = DefInhibitCycles,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic        clk,
   input  logic        reset,
   ps2_cmd_tx_if.slave cmd,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic        ps2_clk_oe,
   output logic        ps2_dat_oe
);

   localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned FallW  = $clog2(FrameFalls + 1);
   localparam int unsigned unused_clk_hz = CLK_HZ;

   localparam logic [CntW-1:0]  InhibitLast = CntW'(INHIBIT_CYCLES - 1);
   localparam logic [CntW-1:0]  TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
   // Fall count already seen when the stop-bit fall arrives.
   localparam logic [FallW-1:0] StopFallCnt = FallW'(FrameFalls - 2);

   ps2_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [FallW-1:0] fall_cnt_q, fall_cnt_d;
   logic [8:0]       shift_q, shift_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic clk_sync;
   logic clk_fall;
   logic dat_sync;
   logic unused_dat_fall;
   logic timeout;
   logic in_frame;

   ps2_sync_edge u_clk_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (ps2_clk_in),
      .sync    (clk_sync),
      .fall    (clk_fall)
   );

   ps2_sync_edge u_dat_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (ps2_dat_in),
      .sync    (dat_sync),
      .fall    (unused_dat_fall)
   );

   assign timeout  = (cnt_q == TimeoutLast);
   assign in_frame = state_q inside {StRts, StData, StAck, StWaitIdle};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CntW'(1);
      fall_cnt_d = fall_cnt_q;
      shift_d    = shift_q;
      clk_oe_d   = 1'b0;
      dat_oe_d   = dat_oe_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         StIdle: begin
            cnt_d    = '0;
            dat_oe_d = 1'b0;
            if (cmd.cmd_valid) begin
               shift_d  = {odd_parity(cmd.cmd_data), cmd.cmd_data};
               clk_oe_d = 1'b1;
               state_d  = StInhibit;
            end
         end

         StInhibit: begin
            if (cnt_q == InhibitLast) begin
               state_d    = StRts;
               cnt_d      = '0;
               fall_cnt_d = '0;
               dat_oe_d   = 1'b1;
            end else begin
               clk_oe_d = 1'b1;
            end
         end

         StRts: begin
            if (clk_fall) begin
               dat_oe_d   = ~shift_q[0];
               shift_d    = {1'b0, shift_q[8:1]};
               fall_cnt_d = FallW'(1);
               state_d    = StData;
            end
         end

         StData: begin
            if (clk_fall) begin
               fall_cnt_d = fall_cnt_q + FallW'(1);
               if (fall_cnt_q == StopFallCnt) begin
                  dat_oe_d = 1'b0;
                  state_d  = StAck;
               end else begin
                  // Bits 1..7, then parity once the data byte has shifted out.
                  dat_oe_d = ~shift_q[0];
                  shift_d  = {1'b0, shift_q[8:1]};
               end
            end
         end

         StAck: begin
            if (clk_fall) begin
               fall_cnt_d = fall_cnt_q + FallW'(1);
               if (dat_sync) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StWaitIdle;
               end
            end
         end

         StWaitIdle: begin
            if (clk_sync && dat_sync) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end

         default: begin
            state_d  = StIdle;
            cnt_d    = '0;
            dat_oe_d = 1'b0;
         end
      endcase

      // Timeout wins over any same-cycle ack or done.
      if (in_frame && timeout) begin
         state_d  = StIdle;
         dat_oe_d = 1'b0;
         done_d   = 1'b0;
         err_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         fall_cnt_q <= '0;
         shift_q    <= '0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fall_cnt_q <= fall_cnt_d;
         shift_q    <= shift_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign ps2_clk_oe    = clk_oe_q;
   assign ps2_dat_oe    = dat_oe_q;
   assign cmd.tx_done   = done_q;
   assign cmd.tx_error  = err_q;
   assign cmd.busy      = (state_q != StIdle);
   assign cmd.cmd_ready = (state_q == StIdle) && !reset;

endmodule

// File: tb/tb_ps2_cmd_tx.sv
// Bench for ps2_cmd_tx: a PS/2 device model clocks frames out of the DUT and
// compares the captured bits and status pulses with a byte-level frame model.
module tb_ps2_cmd_tx;

   localparam int unsigned Inhibit  = 1000;
   localparam int unsigned Timeout  = 3000;
   localparam int          LowHalf  = 10;
   localparam int          HighHalf = 10;

   logic clk = 1'b0;
   logic reset;
   logic dev_clk;
   logic dev_dat;
   logic ps2_clk_in;
   logic ps2_dat_in;
   logic ps2_clk_oe;
   logic ps2_dat_oe;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;
   int err_cnt     = 0;
   bit both_seen   = 1'b0;

   ps2_cmd_tx_if bus ();

   // Open-drain wires: either side may pull low.
   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_cmd_tx #(
      .CLK_HZ         (50000000),
      .INHIBIT_CYCLES (Inhibit),
      .TIMEOUT_CYCLES (Timeout)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd        (bus),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.tx_done === 1'b1) done_cnt++;
      if (bus.tx_error === 1'b1) err_cnt++;
      if (bus.tx_done === 1'b1 && bus.tx_error === 1'b1) both_seen = 1'b1;
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: observed no end of run, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Bits as they appear on the wire: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
   function automatic logic [10:0] frame_model(input logic [7:0] b);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
   endfunction

   // mode: 0 device acks, 1 device leaves data high, 2 device never clocks, 3 reset after fall 5
   task automatic send(input logic [7:0] b, input int mode, input string name);
      int          waited;
      int          inh;
      int          c;
      int          d0;
      int          e0;
      bit          bad;
      logic [10:0] seen;
      logic [10:0] exp_f;

      exp_f  = frame_model(b);
      seen   = '0;
      waited = 0;
      while (bus.cmd_ready !== 1'b1 && waited < 200) begin
         cyc(1);
         waited++;
      end
      check({name, "_ready"}, 32'(bus.cmd_ready), 32'd1);
      d0 = done_cnt;
      e0 = err_cnt;

      bus.cmd_valid = 1'b1;
      bus.cmd_data  = b;
      cyc(1);
      // Keep offering junk while inhibited; none of it may be taken.
      inh = 0;
      bad = 1'b0;
      while (ps2_clk_oe === 1'b1 && inh < int'(Inhibit) + 50) begin
         if (bus.cmd_ready !== 1'b0 || ps2_dat_oe !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
         bus.cmd_data = 8'($urandom);
         inh++;
         cyc(1);
      end
      bus.cmd_valid = 1'b0;
      check({name, "_inhibit_len"}, 32'(inh), 32'(Inhibit));
      check({name, "_inhibit_ready_low"}, 32'(bad), 32'd0);
      check({name, "_rts_start_drive"}, 32'(ps2_dat_oe), 32'd1);

      if (mode == 2) begin
         c = 0;
         while (bus.tx_error !== 1'b1 && c < int'(Timeout) + 50) begin
            cyc(1);
            c++;
         end
         check({name, "_timeout_len"}, 32'(c), 32'(Timeout));
         check({name, "_released"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
         cyc(3);
         check({name, "_err_pulses"}, 32'(err_cnt - e0), 32'd1);
         check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd0);
         check({name, "_idle"}, 32'(bus.busy), 32'd0);
         return;
      end

      cyc(HighHalf);
      seen[0] = ps2_dat_in;
      for (int k = 1; k <= 11; k++) begin
         dev_clk = 1'b0;
         cyc(LowHalf);
         if (k <= 10) seen[k] = ps2_dat_in;
         dev_clk = 1'b1;
         if (k == 10 && mode == 0) dev_dat = 1'b0;
         if (k == 5 && mode == 3) begin
            reset = 1'b1;
            cyc(1);
            check({name, "_reset_released"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
            check({name, "_reset_idle"}, 32'(bus.busy), 32'd0);
            check({name, "_reset_ready_low"}, 32'(bus.cmd_ready), 32'd0);
            reset = 1'b0;
            cyc(1);
            check({name, "_ready_after_reset"}, 32'(bus.cmd_ready), 32'd1);
            cyc(60);
            check({name, "_no_pulses"}, 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
            return;
         end
         cyc(HighHalf);
      end

      check({name, "_frame"}, 32'(seen), 32'(exp_f));
      check({name, "_parity"}, 32'(seen[9]), 32'(exp_f[9]));

      if (mode == 0) begin
         dev_dat = 1'b1;
         c = 0;
         while (bus.tx_done !== 1'b1 && c < 200) begin
            cyc(1);
            c++;
         end
         cyc(3);
         check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
         check({name, "_err_pulses"}, 32'(err_cnt - e0), 32'd0);
      end else begin
         cyc(3);
         check({name, "_err_pulses"}, 32'(err_cnt - e0), 32'd1);
         check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd0);
      end
      check({name, "_released"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      check({name, "_back_idle"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      reset         = 1'b1;
      dev_clk       = 1'b1;
      dev_dat       = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 8'h00;
      cyc(3);
      check("reset_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      check("reset_pulses", {30'd0, bus.tx_done, bus.tx_error}, 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_ready", 32'(bus.cmd_ready), 32'd0);
      reset = 1'b0;
      cyc(1);
      check("ready_first_cycle", 32'(bus.cmd_ready), 32'd1);

      send(8'hF4, 0, "f4");
      send(8'hFF, 0, "ff");
      send(8'h00, 0, "zero");
      send(8'($urandom), 1, "nack");
      send(8'($urandom), 2, "timeout");
      send(8'hF4, 3, "reset_mid");
      send(8'hF4, 0, "f4_again");
      for (int i = 0; i < 4; i++) send(8'($urandom), 0, "rand");

      check("done_err_exclusive", 32'(both_seen), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
